// File: rtl/apu_mem_pkg.sv
// Shared types for the APU memory responder: FSM states, error-flag bit positions
// and the latched request record.
package apu_mem_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ROM_WAIT,
    RAM_WAIT,
    RESP,
    HOLD
  } state_t;

  localparam int ERR_ROM_WR = 0;
  localparam int ERR_RAM_TO = 1;
  localparam int ERR_ACCESS = 2;
  localparam int ERR_W      = 3;

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] wdata;
    logic        is_write;
    logic        is_ram;
  } req_t;

endpackage

// File: rtl/apu_mem_timeout.sv
// Loadable down-counter that flags expiry when it reaches zero.
// Loading takes priority over decrementing; the count parks at zero.
module apu_mem_timeout #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         dec,
  output logic         expired
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/apu_mem_responder.sv
// Target-side responder for the APU bus: serves level-held read/write requests from
// program BRAM or main RAM and answers with one-cycle dataReady / writeAcknowledge pulses.
module apu_mem_responder
  import apu_mem_pkg::*;
#(
  parameter int          ROM_ADDR_W   = 10,
  parameter int          RAM_TIMEOUT  = 255,
  parameter logic [15:0] TIMEOUT_DATA = 16'hDEAD
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           address,
  input  logic [15:0]           dataOut,
  input  logic                  writeEnable,
  input  logic                  readEnable,
  input  logic                  readRAM,
  output logic [15:0]           dataIn,
  output logic                  dataReady,
  output logic                  writeAcknowledge,
  output logic [ROM_ADDR_W-1:0] romAddress,
  output logic                  romReadEnable,
  input  logic [15:0]           romData,
  output logic [31:0]           ramAddress,
  output logic [15:0]           ramWriteData,
  output logic                  ramRead,
  output logic                  ramWrite,
  input  logic [15:0]           ramReadData,
  input  logic                  ramAck,
  input  logic                  errorClear,
  output logic [2:0]            errorFlags
);

  localparam int TW = $clog2(RAM_TIMEOUT + 1);

  state_t           state, state_nxt;
  req_t             req;
  logic             accept, in_range, rom_rd, to_load, to_expired, ram_done;
  logic [ERR_W-1:0] err_set;

  assign accept   = (state == IDLE) && (writeEnable || readEnable);
  // Upper address bits are compared, so an out-of-range address never aliases into the ROM.
  assign in_range = (address >> ROM_ADDR_W) == 32'd0;
  assign ram_done = (state == RAM_WAIT) && (ramAck || to_expired);

  apu_mem_timeout #(.W(TW)) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .load     (to_load),
    .load_val (TW'(RAM_TIMEOUT - 1)),
    .dec      ((state == RAM_WAIT) && !ramAck),
    .expired  (to_expired)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rom_rd    = 1'b0;
    to_load   = 1'b0;
    err_set   = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (writeEnable && readEnable) err_set[ERR_ACCESS] = 1'b1;
          if (readRAM) begin
            to_load   = 1'b1;
            state_nxt = RAM_WAIT;
          end else if (writeEnable) begin
            err_set[ERR_ROM_WR] = 1'b1;
            state_nxt           = RESP;
          end else if (in_range) begin
            rom_rd    = 1'b1;
            state_nxt = ROM_WAIT;
          end else begin
            err_set[ERR_ACCESS] = 1'b1;
            state_nxt           = RESP;
          end
        end
      end
      ROM_WAIT: state_nxt = RESP;
      RAM_WAIT: begin
        // A late ack in the expiry cycle still counts as a normal completion.
        if (ramAck) begin
          state_nxt = RESP;
        end else if (to_expired) begin
          err_set[ERR_RAM_TO] = 1'b1;
          state_nxt           = RESP;
        end
      end
      RESP:    state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req        <= '0;
      dataIn     <= '0;
      ramRead    <= 1'b0;
      ramWrite   <= 1'b0;
      errorFlags <= '0;
    end else begin
      errorFlags <= (errorClear ? 3'b000 : errorFlags) | err_set;
      if (accept) begin
        req <= '{addr: address, wdata: dataOut, is_write: writeEnable, is_ram: readRAM};
        if (readRAM) begin
          ramWrite <= writeEnable;
          ramRead  <= !writeEnable;
        end else if (!writeEnable && !in_range) begin
          dataIn <= TIMEOUT_DATA;
        end
      end
      if (state == ROM_WAIT) dataIn <= romData;
      if (ram_done) begin
        ramRead  <= 1'b0;
        ramWrite <= 1'b0;
        if (!req.is_write) dataIn <= ramAck ? ramReadData : TIMEOUT_DATA;
      end
    end
  end

  // ROM strobe is issued combinationally in the IDLE sample cycle to meet the 2-cycle read latency.
  assign romReadEnable    = rom_rd && rst;
  assign romAddress       = romReadEnable ? address[ROM_ADDR_W-1:0] : '0;
  assign ramAddress       = req.is_ram ? req.addr : 32'd0;
  assign ramWriteData     = req.is_ram ? req.wdata : 16'd0;
  assign dataReady        = (state == RESP) && !req.is_write;
  assign writeAcknowledge = (state == RESP) && req.is_write;

endmodule

// File: tb/tb_apu_mem_responder.sv
// Bench for apu_mem_responder: ROM/RAM environment models, a directed vector table,
// hand-written corner sequences and randomized traffic against a reference model.
module tb_apu_mem_responder;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] address;
  logic [15:0] dataOut;
  logic        writeEnable, readEnable, readRAM;
  logic [15:0] dataIn;
  logic        dataReady, writeAcknowledge;
  logic [9:0]  romAddress;
  logic        romReadEnable;
  logic [15:0] romData;
  logic [31:0] ramAddress;
  logic [15:0] ramWriteData;
  logic        ramRead, ramWrite;
  logic [15:0] ramReadData;
  logic        ramAck;
  logic        errorClear;
  logic [2:0]  errorFlags;

  apu_mem_responder #(.ROM_ADDR_W(10), .RAM_TIMEOUT(T), .TIMEOUT_DATA(16'hDEAD)) dut (
    .clk(clk), .rst(rst), .address(address), .dataOut(dataOut),
    .writeEnable(writeEnable), .readEnable(readEnable), .readRAM(readRAM),
    .dataIn(dataIn), .dataReady(dataReady), .writeAcknowledge(writeAcknowledge),
    .romAddress(romAddress), .romReadEnable(romReadEnable), .romData(romData),
    .ramAddress(ramAddress), .ramWriteData(ramWriteData), .ramRead(ramRead),
    .ramWrite(ramWrite), .ramReadData(ramReadData), .ramAck(ramAck),
    .errorClear(errorClear), .errorFlags(errorFlags)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ROM: data is a fixed function of the address, valid one cycle after the strobe.
  always @(posedge clk) if (romReadEnable) romData <= 16'(romAddress) ^ 16'h1234;

  // RAM: acknowledges ram_lat cycles after the first request cycle (255 = never).
  int ram_lat = 255;
  int ram_cnt = 0;
  logic [15:0] ram_mem [logic [31:0]];
  always @(negedge clk) begin
    ramAck = 1'b0;
    if (ramRead || ramWrite) begin
      if (ram_cnt == ram_lat) begin
        ramAck = 1'b1;
        if (ramWrite) ram_mem[ramAddress] = ramWriteData;
        else ramReadData = ram_mem.exists(ramAddress) ? ram_mem[ramAddress] : 16'h0000;
        ram_cnt = 0;
      end else begin
        ram_cnt++;
      end
    end else begin
      ram_cnt = 0;
    end
  end

  int rom_pulses = 0, ram_hi = 0, overlap = 0, dbl_pulse = 0, pulse_cnt = 0;
  logic prev_pulse = 1'b0;
  always @(negedge clk) begin
    if (romReadEnable) rom_pulses++;
    if (ramRead || ramWrite) ram_hi++;
    if (ramRead && ramWrite) overlap++;
    if (dataReady || writeAcknowledge) pulse_cnt++;
    if ((dataReady || writeAcknowledge) && prev_pulse) dbl_pulse++;
    prev_pulse = dataReady || writeAcknowledge;
  end

  typedef struct {
    logic        we, re, rr, clr;
    logic [31:0] addr;
    logic [15:0] wd;
    int          lat;
    logic [15:0] exp_dat;
    int          exp_lat;
    logic        exp_wr;
    logic [2:0]  exp_flags;
  } vec_t;

  task automatic run_req(input vec_t v, input string tag);
    int n, rom0, rq0;
    logic seen_en, rom_exp;
    logic [9:0] seen_addr;
    if (v.clr) begin
      @(posedge clk); #1 errorClear = 1'b1;
      @(posedge clk); #1 errorClear = 1'b0;
      @(negedge clk);
      chk({tag, " clear"}, 32'(errorFlags), 32'd0);
    end
    ram_lat = v.lat;
    rom0 = rom_pulses;
    rq0 = ram_hi;
    @(posedge clk); #1;
    writeEnable = v.we; readEnable = v.re; readRAM = v.rr;
    address = v.addr; dataOut = v.wd;
    n = 0;
    @(negedge clk);
    seen_en = romReadEnable;
    seen_addr = romAddress;
    while (!(dataReady || writeAcknowledge) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({tag, " latency"}, 32'(n), 32'(v.exp_lat));
    chk({tag, " kind"}, {30'd0, dataReady, writeAcknowledge}, {30'd0, !v.exp_wr, v.exp_wr});
    chk({tag, " data"}, 32'(dataIn), 32'(v.exp_dat));
    chk({tag, " flags"}, 32'(errorFlags), 32'(v.exp_flags));
    @(posedge clk); #1;
    writeEnable = 1'b0; readEnable = 1'b0;
    @(negedge clk); #1;
    chk({tag, " hold no pulse"}, {30'd0, dataReady, writeAcknowledge}, 32'd0);
    chk({tag, " data held"}, 32'(dataIn), 32'(v.exp_dat));
    rom_exp = !v.we && v.re && !v.rr && (v.addr < 32'd1024);
    chk({tag, " rom strobes"}, 32'(rom_pulses - rom0), 32'(rom_exp));
    if (rom_exp) chk({tag, " rom addr"}, 32'(seen_addr), 32'(v.addr[9:0]));
    else chk({tag, " rom idle"}, 32'(seen_en), 32'd0);
    if (v.rr) chk({tag, " ram req cycles"}, 32'(ram_hi - rq0), 32'((v.lat >= T) ? T : v.lat + 1));
  endtask

  vec_t tbl[13];
  vec_t v;
  logic [15:0] mdat;
  logic [2:0]  mflags, ferr;
  logic [15:0] ref_mem [logic [31:0]];

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    //        we    re    rr    clr   addr           wd        lat  exp_dat   lat wr    flags
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd5,        16'h0000, 0,   16'h1231, 2, 1'b0, 3'b000};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 32'h40,       16'hBEEF, 2,   16'h1231, 4, 1'b1, 3'b000};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h40,       16'h0000, 0,   16'hBEEF, 2, 1'b0, 3'b000};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h44,       16'h0000, 255, 16'hDEAD, 9, 1'b0, 3'b010};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b1, 32'd3,        16'h5555, 0,   16'hDEAD, 1, 1'b1, 3'b001};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd2048,     16'h0000, 0,   16'hDEAD, 1, 1'b0, 3'b100};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h80,       16'h1111, 1,   16'hDEAD, 3, 1'b1, 3'b100};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 1'b0, 32'h80,       16'h0000, 7,   16'h1111, 9, 1'b0, 3'b100};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 32'd1023,     16'h0000, 0,   16'h11CB, 2, 1'b0, 3'b000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd1024,     16'h0000, 0,   16'hDEAD, 1, 1'b0, 3'b100};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1'b1, 32'h80000005, 16'h0000, 0,   16'hDEAD, 1, 1'b0, 3'b100};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 32'd5,        16'h7777, 0,   16'hDEAD, 1, 1'b1, 3'b101};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd0,        16'h0000, 0,   16'h1234, 2, 1'b0, 3'b101};

    rst = 1'b0; address = '0; dataOut = '0; writeEnable = 1'b0; readEnable = 1'b0;
    readRAM = 1'b0; errorClear = 1'b0; romData = '0; ramReadData = '0; ramAck = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset dataIn", 32'(dataIn), 32'd0);
    chk("reset strobes", {27'd0, dataReady, writeAcknowledge, romReadEnable, ramRead, ramWrite}, 32'd0);
    chk("reset ramAddress", ramAddress, 32'd0);
    chk("reset romAddress/wdata", {6'd0, romAddress, ramWriteData}, 32'd0);
    chk("reset flags", 32'(errorFlags), 32'd0);
    @(posedge clk); #1 rst = 1'b1;

    for (int i = 0; i < 13; i++) run_req(tbl[i], $sformatf("vec%0d", i));

    // Held read enable: each IDLE sample starts a ROM read, repeating every 4 cycles.
    begin
      int next_free, exp_n, got_n;
      logic [15:0] exp_mask, got_mask;
      next_free = 0; exp_n = 0; exp_mask = '0; got_mask = '0; got_n = rom_pulses;
      for (int c = 0; c < 10; c++)
        if (c >= next_free) begin
          exp_mask[c+2] = 1'b1;
          next_free = c + 4;
          exp_n++;
        end
      @(posedge clk); #1;
      readEnable = 1'b1; readRAM = 1'b0; address = 32'd5;
      for (int c = 0; c < 14; c++) begin
        if (c > 0) begin
          @(posedge clk); #1;
          if (c == 10) readEnable = 1'b0;
        end
        @(negedge clk);
        if (dataReady) begin
          got_mask[c] = 1'b1;
          chk("held data", 32'(dataIn), 32'h1231);
        end
      end
      chk("held pulse cycles", 32'(got_mask), 32'(exp_mask));
      chk("held rom strobes", 32'(rom_pulses - got_n), 32'(exp_n));
    end

    // Clear coinciding with a new ROM-write error: the new error survives the clear.
    @(posedge clk); #1;
    writeEnable = 1'b1; readRAM = 1'b0; address = 32'd3; errorClear = 1'b1;
    @(posedge clk); #1 errorClear = 1'b0;
    @(negedge clk);
    chk("clr+err ack", 32'(writeAcknowledge), 32'd1);
    chk("clr+err flags", 32'(errorFlags), 32'b001);
    @(posedge clk); #1 writeEnable = 1'b0;
    repeat (2) @(negedge clk);

    // Asynchronous reset while waiting on RAM.
    begin
      int p0;
      ram_lat = 255;
      @(posedge clk); #1;
      readEnable = 1'b1; readRAM = 1'b1; address = 32'h200;
      @(negedge clk);
      @(negedge clk);
      chk("rst-mid ramRead before", 32'(ramRead), 32'd1);
      p0 = pulse_cnt;
      #2 rst = 1'b0;
      #1;
      chk("rst-mid ramRead dropped", 32'(ramRead), 32'd0);
      readEnable = 1'b0; readRAM = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("rst-mid no response", 32'(pulse_cnt - p0), 32'd0);
      v = '{1'b0, 1'b1, 1'b0, 1'b0, 32'd7, 16'h0, 0, 16'h1233, 2, 1'b0, 3'b000};
      run_req(v, "post-reset rom");
    end

    // Randomized traffic against the reference model.
    mdat = 16'h1233;
    mflags = 3'b000;
    for (int i = 0; i < 40; i++) begin
      int k;
      k = $urandom_range(0, 9);
      v.we = (k >= 5);
      v.re = (k <= 4) || (k == 9);
      v.rr = 1'($urandom_range(0, 1));
      v.clr = ($urandom_range(0, 3) == 0);
      if (v.rr) v.addr = 32'h100 + 32'($urandom_range(0, 7));
      else if ($urandom_range(0, 7) == 0) v.addr = $urandom;
      else v.addr = 32'($urandom_range(0, 1100));
      v.wd = 16'($urandom);
      v.lat = $urandom_range(0, 9);
      if (v.clr) mflags = 3'b000;
      ferr = 3'b000;
      if (v.we && v.re) ferr[2] = 1'b1;
      if (!v.rr) begin
        if (v.we) begin
          ferr[0] = 1'b1; v.exp_lat = 1;
        end else if (v.addr < 32'd1024) begin
          mdat = v.addr[15:0] ^ 16'h1234; v.exp_lat = 2;
        end else begin
          mdat = 16'hDEAD; ferr[2] = 1'b1; v.exp_lat = 1;
        end
      end else if (v.lat >= T) begin
        ferr[1] = 1'b1; v.exp_lat = T + 1;
        if (!v.we) mdat = 16'hDEAD;
      end else begin
        v.exp_lat = v.lat + 2;
        if (v.we) ref_mem[v.addr] = v.wd;
        else mdat = ref_mem.exists(v.addr) ? ref_mem[v.addr] : 16'h0000;
      end
      mflags |= ferr;
      v.exp_dat = mdat;
      v.exp_wr = v.we;
      v.exp_flags = mflags;
      run_req(v, $sformatf("rand%0d", i));
    end

    chk("ram read/write overlap cycles", 32'(overlap), 32'd0);
    chk("multi-cycle response pulses", 32'(dbl_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
